labelled_array_ctrl: RTL and testbench
======================================

Name: labelled_array_ctrl

Overview:
- Parametrised, label-tracked register array with one write port and one read port; each entry carries data plus a LABEL_W security tag.
- Writes whose joined label (data ⊔ index ⊔ context) exceeds the array ceiling are rejected, flagged and counted.
- Reads are clearance-checked and registered.
- Includes a sequential scrub engine that zeroes all entries and tags; used as the labelled scratch storage beside datapath register files.

Parameters:
- DATA_W, 16, entry width in bits
- DEPTH, 4, number of entries (≥2)
- IDX_W, $clog2(DEPTH), index width
- LABEL_W, 2, label width; labels are integers ordered by unsigned compare, join = max
- ARRAY_CEIL, 0, highest label the array may hold
- CNT_W, 8, violation counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  high when not scrubbing
- wr_idx  in  IDX_W  write index
- wr_data  in  DATA_W  write data
- wr_mask  in  DATA_W  per-bit write enable
- wr_lbl_data, wr_lbl_idx, wr_lbl_ctx  in  LABEL_W each  labels of data, index, control context
- wr_err  out  1  one-cycle pulse: previous write rejected
- rd_valid  in  1  read request
- rd_idx  in  IDX_W  read index
- rd_lbl_idx  in  LABEL_W  label of read index
- rd_clr  in  LABEL_W  reader clearance
- rd_resp_valid  out  1  response valid (1 cycle after rd_valid)
- rd_data  out  DATA_W  response data
- rd_lbl  out  LABEL_W  response label
- rd_denied  out  1  response suppressed by clearance
- scrub_req  in  1  start scrub (level, sampled when idle)
- scrub_busy  out  1  scrub in progress
- viol_count  out  CNT_W  saturating count of rejected writes

Behaviour:
- Reset (reset=0, async): all entries and tags 0; wr_err, rd_resp_valid, rd_denied, scrub_busy = 0; rd_data = 0; rd_lbl = 0; viol_count = 0; FSM = IDLE; wr_ready = 1 once reset deasserts.
- Write accept: wr_valid & wr_ready. J = max(wr_lbl_data, wr_lbl_idx, wr_lbl_ctx).
  - If J > ARRAY_CEIL, or wr_idx ≥ DEPTH: no state change; wr_err=1 next cycle; viol_count += 1, saturating at all-ones.
  - Otherwise: data ← (old & ~mask) | (wr_data & mask).
  - Tag ← J if mask is all-ones, else max(old tag, J).
  - mask = 0: accepted, no data or tag change, no error.
- Write while wr_ready=0: ignored; no error, no count.
- Read: rd_valid at cycle N gives response at N+1 with rd_resp_valid=1. E = max(tag[rd_idx], rd_lbl_idx).
  - If E > rd_clr or rd_idx ≥ DEPTH: rd_denied=1, rd_data=0, rd_lbl=0.
  - Otherwise: rd_data = entry, rd_lbl = E, rd_denied=0.
  - Without rd_valid: rd_resp_valid=0 and other read outputs hold.
- Read and write to the same index in the same cycle: read returns the pre-write data and tag.
- Reads are serviced during scrub and see the partially scrubbed state.
- Scrub FSM, IDLE → SCRUB → IDLE:
  - IDLE with scrub_req=1 enters SCRUB next cycle: scrub_busy=1, wr_ready=0, ptr=0.
  - SCRUB clears entry[ptr] and tag[ptr] each cycle and increments ptr.
  - After clearing DEPTH-1, returns to IDLE. Busy lasts exactly DEPTH cycles.
  - scrub_req during SCRUB is ignored. A write accepted in the cycle scrub_req is sampled still completes.
- Reset mid-scrub: FSM → IDLE, array cleared by reset.
- viol_count is unaffected by scrub.

Decomposition:
- Package labelled_array_pkg holds:
  - label_t typedef (LABEL_W)
  - label_join function (max)
  - label_leq compare function
  - scrub state enum {IDLE, SCRUB}
- One sub-module, labelled_array_scrub: FSM plus pointer. Outputs scrub_busy, clr_en, clr_idx.

Test Plan:
- DATA_W=16, LABEL_W=2, ARRAY_CEIL=1. Write idx 2, data 0xBEEF, mask 0xFFFF, labels (1,0,0); read idx 2 with clr 1 → next cycle rd_data=0xBEEF, rd_lbl=1, rd_denied=0.
- Same entry, read with clr 0 → rd_denied=1, rd_data=0, rd_lbl=0. Then write idx 1 with lbl_idx=2 → wr_err pulse, viol_count=1, entry 1 unchanged.
- Masked write idx 2, data 0x0012, mask 0x00FF, labels all 0 → entry 0xBE12, tag stays 1. Full-mask write, labels 0 → tag 0.
- Same-cycle read and write idx 0 (old 0x1111, new 0x2222) → response 0x1111; read next cycle → 0x2222.
- Fill all 4 entries, pulse scrub_req → scrub_busy high exactly 4 cycles, wr_ready low; a write issued mid-scrub has no effect; afterwards all reads return 0 with tag 0.
- CNT_W=2: issue 5 rejected writes → viol_count reads 3. Assert reset mid-scrub → scrub_busy=0 and viol_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/labelled_array_pkg.sv
// Shared label type, lattice helpers and scrub state encoding for the labelled array.
package labelled_array_pkg;

    localparam int unsigned LBL_W = 2;

    typedef logic [LBL_W-1:0] label_t;

    typedef enum logic {
        IDLE,
        SCRUB
    } scrub_state_e;

    function automatic label_t label_join(input label_t a, input label_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic label_leq(input label_t a, input label_t b);
        return a <= b;
    endfunction

endpackage

// File: rtl/labelled_array_ctrl_if.sv
// Write and read channels of the labelled array; slave is the array side.
interface labelled_array_ctrl_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned LABEL_W = 2
);
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  wr_mask;
    logic [LABEL_W-1:0] wr_lbl_data;
    logic [LABEL_W-1:0] wr_lbl_idx;
    logic [LABEL_W-1:0] wr_lbl_ctx;
    logic               wr_err;

    logic               rd_valid;
    logic [IDX_W-1:0]   rd_idx;
    logic [LABEL_W-1:0] rd_lbl_idx;
    logic [LABEL_W-1:0] rd_clr;
    logic               rd_resp_valid;
    logic [DATA_W-1:0]  rd_data;
    logic [LABEL_W-1:0] rd_lbl;
    logic               rd_denied;

    modport slave (
        input  wr_valid, wr_idx, wr_data, wr_mask, wr_lbl_data, wr_lbl_idx, wr_lbl_ctx,
        input  rd_valid, rd_idx, rd_lbl_idx, rd_clr,
        output wr_ready, wr_err, rd_resp_valid, rd_data, rd_lbl, rd_denied
    );

    modport master (
        output wr_valid, wr_idx, wr_data, wr_mask, wr_lbl_data, wr_lbl_idx, wr_lbl_ctx,
        output rd_valid, rd_idx, rd_lbl_idx, rd_clr,
        input  wr_ready, wr_err, rd_resp_valid, rd_data, rd_lbl, rd_denied
    );

endinterface

// File: rtl/labelled_array_scrub.sv
// Sequential scrub engine: walks every index once, asserting a clear strobe per entry.
module labelled_array_scrub
    import labelled_array_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scrub_req,
    output logic             scrub_busy,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx
);

    scrub_state_e     state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scrub_req) begin
                        state_q <= SCRUB;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCRUB: begin
                    // Busy spans exactly DEPTH cycles: leave on the cycle that clears the last entry.
                    if (32'(ptr_q) == DEPTH - 1) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scrub_busy = busy_q;
    assign clr_en     = busy_q;
    assign clr_idx    = ptr_q;

endmodule

// File: rtl/labelled_array_ctrl.sv
// Label-tracked register array: ceiling-checked masked writes, clearance-checked
// registered reads, saturating violation counter and a sequential scrub.
module labelled_array_ctrl
    import labelled_array_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IDX_W      = $clog2(DEPTH),
    parameter int unsigned LABEL_W    = LBL_W,
    parameter int unsigned ARRAY_CEIL = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    labelled_array_ctrl_if.slave  bus,
    input  logic                  scrub_req,
    output logic                  scrub_busy,
    output logic [CNT_W-1:0]      viol_count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    label_t            tag_q [DEPTH];

    logic              wr_err_q;
    logic              rd_resp_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    label_t            rd_lbl_q;
    logic              rd_denied_q;
    logic [CNT_W-1:0]  viol_q;

    logic              clr_en;
    logic [IDX_W-1:0]  clr_idx;

    labelled_array_scrub #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_scrub (
        .clk        (clk),
        .reset      (reset),
        .scrub_req  (scrub_req),
        .scrub_busy (scrub_busy),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx)
    );

    logic              wr_fire;
    logic              wr_idx_ok;
    label_t            wr_join;
    logic              wr_reject;
    logic              wr_commit;
    logic [DATA_W-1:0] wr_data_d;
    label_t            wr_tag_d;

    assign bus.wr_ready = ~scrub_busy;
    assign wr_fire      = bus.wr_valid & bus.wr_ready;
    assign wr_idx_ok    = 32'(bus.wr_idx) < DEPTH;
    assign wr_join      = label_join(label_join(bus.wr_lbl_data, bus.wr_lbl_idx), bus.wr_lbl_ctx);
    assign wr_reject    = wr_fire & (~wr_idx_ok | ~label_leq(wr_join, label_t'(ARRAY_CEIL)));
    assign wr_commit    = wr_fire & ~wr_reject & (|bus.wr_mask);

    always_comb begin
        wr_data_d = '0;
        wr_tag_d  = '0;
        if (wr_idx_ok) begin
            wr_data_d = (mem_q[bus.wr_idx] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
            // A partial write leaves old bits behind, so the old tag must still cover them.
            wr_tag_d  = (&bus.wr_mask) ? wr_join : label_join(tag_q[bus.wr_idx], wr_join);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (clr_en) begin
            mem_q[clr_idx] <= '0;
            tag_q[clr_idx] <= '0;
        end else if (wr_commit) begin
            mem_q[bus.wr_idx] <= wr_data_d;
            tag_q[bus.wr_idx] <= wr_tag_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err_q <= 1'b0;
            viol_q   <= '0;
        end else begin
            wr_err_q <= wr_reject;
            if (wr_reject && (viol_q != '1)) begin
                viol_q <= viol_q + 1'b1;
            end
        end
    end

    logic   rd_idx_ok;
    label_t rd_eff;
    logic   rd_deny;

    assign rd_idx_ok = 32'(bus.rd_idx) < DEPTH;
    assign rd_eff    = label_join(rd_idx_ok ? tag_q[bus.rd_idx] : '0, bus.rd_lbl_idx);
    assign rd_deny   = ~rd_idx_ok | ~label_leq(rd_eff, bus.rd_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_resp_valid_q <= 1'b0;
            rd_data_q       <= '0;
            rd_lbl_q        <= '0;
            rd_denied_q     <= 1'b0;
        end else begin
            rd_resp_valid_q <= bus.rd_valid;
            if (bus.rd_valid) begin
                rd_denied_q <= rd_deny;
                rd_data_q   <= rd_deny ? '0 : mem_q[bus.rd_idx];
                rd_lbl_q    <= rd_deny ? '0 : rd_eff;
            end
        end
    end

    assign bus.wr_err        = wr_err_q;
    assign bus.rd_resp_valid = rd_resp_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_lbl        = rd_lbl_q;
    assign bus.rd_denied     = rd_denied_q;
    assign viol_count        = viol_q;

endmodule

// File: tb/tb_labelled_array_ctrl.sv
// Directed-vector bench for labelled_array_ctrl (DEPTH=4, ARRAY_CEIL=1, CNT_W=2).
module tb_labelled_array_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LBL_W  = 2;
    localparam int unsigned CNT_W  = 2;

    logic             clk;
    logic             reset;
    logic             scrub_req;
    logic             scrub_busy;
    logic [CNT_W-1:0] viol_count;

    int vectors;
    int miscompares;

    labelled_array_ctrl_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LABEL_W(LBL_W)) bus ();

    labelled_array_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .LABEL_W    (LBL_W),
        .ARRAY_CEIL (1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .scrub_req  (scrub_req),
        .scrub_busy (scrub_busy),
        .viol_count (viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers start and end on a falling edge; results of the rising edge in between are then visible.
    task automatic wr_cycle(input logic [1:0] idx, input logic [15:0] data, input logic [15:0] mask,
                            input logic [1:0] ld, input logic [1:0] li, input logic [1:0] lc);
        bus.wr_valid = 1'b1; bus.wr_idx = idx; bus.wr_data = data; bus.wr_mask = mask;
        bus.wr_lbl_data = ld; bus.wr_lbl_idx = li; bus.wr_lbl_ctx = lc;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd_cycle(input logic [1:0] idx, input logic [1:0] lidx, input logic [1:0] clr);
        bus.rd_valid = 1'b1; bus.rd_idx = idx; bus.rd_lbl_idx = lidx; bus.rd_clr = clr;
        @(negedge clk);
        bus.rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
        vectors++; if (bus.wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err); end
        vectors++; if (bus.rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_resp_valid: got %b expected 0", bus.rd_resp_valid); end
        vectors++; if (bus.rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0000", bus.rd_data); end
        vectors++; if (bus.rd_lbl !== 2'd0 || bus.rd_denied !== 1'b0) begin miscompares++; $display("FAIL reset_rd_lbl_denied: got %0d/%b expected 0/0", bus.rd_lbl, bus.rd_denied); end
        vectors++; if (scrub_busy !== 1'b0) begin miscompares++; $display("FAIL reset_scrub_busy: got %b expected 0", scrub_busy); end
        vectors++; if (viol_count !== 2'd0) begin miscompares++; $display("FAIL reset_viol_count: got %0d expected 0", viol_count); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_rw();
        wr_cycle(2'd2, 16'hBEEF, 16'hFFFF, 2'd1, 2'd0, 2'd0);
        vectors++; if (bus.wr_err !== 1'b0) begin miscompares++; $display("FAIL basic_wr_err: got %b expected 0", bus.wr_err); end
        rd_cycle(2'd2, 2'd0, 2'd1);
        vectors++; if (bus.rd_resp_valid !== 1'b1) begin miscompares++; $display("FAIL basic_rd_valid: got %b expected 1", bus.rd_resp_valid); end
        vectors++; if (bus.rd_data !== 16'hBEEF) begin miscompares++; $display("FAIL basic_rd_data: got %h expected beef", bus.rd_data); end
        vectors++; if (bus.rd_lbl !== 2'd1 || bus.rd_denied !== 1'b0) begin miscompares++; $display("FAIL basic_rd_lbl_denied: got %0d/%b expected 1/0", bus.rd_lbl, bus.rd_denied); end
        rd_cycle(2'd2, 2'd0, 2'd0);
        vectors++; if (bus.rd_denied !== 1'b1 || bus.rd_data !== 16'h0000 || bus.rd_lbl !== 2'd0) begin miscompares++; $display("FAIL denied_low_clr: got denied=%b data=%h lbl=%0d expected 1/0000/0", bus.rd_denied, bus.rd_data, bus.rd_lbl); end
        rd_cycle(2'd2, 2'd2, 2'd1);
        vectors++; if (bus.rd_denied !== 1'b1) begin miscompares++; $display("FAIL denied_idx_label: got %b expected 1", bus.rd_denied); end
    endtask

    task automatic test_reject();
        wr_cycle(2'd1, 16'h5555, 16'hFFFF, 2'd0, 2'd2, 2'd0);
        vectors++; if (bus.wr_err !== 1'b1) begin miscompares++; $display("FAIL reject_wr_err: got %b expected 1", bus.wr_err); end
        vectors++; if (viol_count !== 2'd1) begin miscompares++; $display("FAIL reject_viol_count: got %0d expected 1", viol_count); end
        rd_cycle(2'd1, 2'd0, 2'd3);
        vectors++; if (bus.wr_err !== 1'b0) begin miscompares++; $display("FAIL reject_err_pulse: got %b expected 0", bus.wr_err); end
        vectors++; if (bus.rd_data !== 16'h0000 || bus.rd_lbl !== 2'd0) begin miscompares++; $display("FAIL reject_entry_kept: got %h/%0d expected 0000/0", bus.rd_data, bus.rd_lbl); end
    endtask

    task automatic test_mask();
        wr_cycle(2'd2, 16'h0012, 16'h00FF, 2'd0, 2'd0, 2'd0);
        rd_cycle(2'd2, 2'd0, 2'd3);
        vectors++; if (bus.rd_data !== 16'hBE12 || bus.rd_lbl !== 2'd1) begin miscompares++; $display("FAIL partial_mask: got %h/%0d expected be12/1", bus.rd_data, bus.rd_lbl); end
        wr_cycle(2'd2, 16'h1234, 16'hFFFF, 2'd0, 2'd0, 2'd0);
        rd_cycle(2'd2, 2'd0, 2'd3);
        vectors++; if (bus.rd_data !== 16'h1234 || bus.rd_lbl !== 2'd0) begin miscompares++; $display("FAIL full_mask_tag: got %h/%0d expected 1234/0", bus.rd_data, bus.rd_lbl); end
        wr_cycle(2'd2, 16'hFFFF, 16'h0000, 2'd1, 2'd0, 2'd0);
        vectors++; if (bus.wr_err !== 1'b0) begin miscompares++; $display("FAIL zero_mask_err: got %b expected 0", bus.wr_err); end
        rd_cycle(2'd2, 2'd1, 2'd1);
        vectors++; if (bus.rd_data !== 16'h1234 || bus.rd_lbl !== 2'd1) begin miscompares++; $display("FAIL zero_mask_nochange: got %h/%0d expected 1234/1", bus.rd_data, bus.rd_lbl); end
    endtask

    task automatic test_back_to_back();
        wr_cycle(2'd0, 16'h1111, 16'hFFFF, 2'd0, 2'd0, 2'd0);
        bus.wr_valid = 1'b1; bus.wr_idx = 2'd0; bus.wr_data = 16'h2222; bus.wr_mask = 16'hFFFF;
        bus.wr_lbl_data = 2'd0; bus.wr_lbl_idx = 2'd0; bus.wr_lbl_ctx = 2'd0;
        bus.rd_valid = 1'b1; bus.rd_idx = 2'd0; bus.rd_lbl_idx = 2'd0; bus.rd_clr = 2'd3;
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        vectors++; if (bus.rd_data !== 16'h1111) begin miscompares++; $display("FAIL same_cycle_old: got %h expected 1111", bus.rd_data); end
        rd_cycle(2'd0, 2'd0, 2'd3);
        vectors++; if (bus.rd_data !== 16'h2222) begin miscompares++; $display("FAIL same_cycle_new: got %h expected 2222", bus.rd_data); end
        @(negedge clk);
        vectors++; if (bus.rd_resp_valid !== 1'b0 || bus.rd_data !== 16'h2222) begin miscompares++; $display("FAIL read_hold: got valid=%b data=%h expected 0/2222", bus.rd_resp_valid, bus.rd_data); end
    endtask

    task automatic test_scrub();
        int busy_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_cycle(2'(i), 16'hA000 + 16'(i), 16'hFFFF, 2'(i % 2), 2'd0, 2'd0);
        end
        busy_cnt = 0;
        scrub_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            scrub_req = 1'b0;
            bus.wr_valid = 1'b0;
            vectors++; if (bus.wr_err !== 1'b0) begin miscompares++; $display("FAIL scrub_no_err: got %b expected 0", bus.wr_err); end
            if (scrub_busy === 1'b1) begin
                busy_cnt++;
                vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL scrub_wr_ready: got %b expected 0", bus.wr_ready); end
                if (busy_cnt == 3) begin
                    bus.wr_valid = 1'b1; bus.wr_idx = 2'd0; bus.wr_data = 16'hDEAD; bus.wr_mask = 16'hFFFF;
                    bus.wr_lbl_data = 2'd0; bus.wr_lbl_idx = 2'd0; bus.wr_lbl_ctx = 2'd0;
                end
            end else if (busy_cnt > 0) begin
                break;
            end
        end
        bus.wr_valid = 1'b0;
        vectors++; if (busy_cnt != 4) begin miscompares++; $display("FAIL scrub_busy_len: got %0d expected 4", busy_cnt); end
        vectors++; if (viol_count !== 2'd1 || bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL scrub_after: got viol=%0d ready=%b expected 1/1", viol_count, bus.wr_ready); end
        for (int i = 0; i < 4; i++) begin
            rd_cycle(2'(i), 2'd0, 2'd0);
            vectors++; if (bus.rd_data !== 16'h0000 || bus.rd_lbl !== 2'd0 || bus.rd_denied !== 1'b0) begin miscompares++; $display("FAIL scrub_cleared[%0d]: got %h/%0d/%b expected 0000/0/0", i, bus.rd_data, bus.rd_lbl, bus.rd_denied); end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            wr_cycle(2'(k % 4), 16'h0F0F, 16'hFFFF, 2'd0, 2'd0, 2'd3);
            vectors++; if (bus.wr_err !== 1'b1) begin miscompares++; $display("FAIL sat_wr_err[%0d]: got %b expected 1", k, bus.wr_err); end
            vectors++; if (viol_count !== exp_cnt[k]) begin miscompares++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, viol_count, exp_cnt[k]); end
        end
    endtask

    task automatic test_reset_mid_scrub();
        wr_cycle(2'd3, 16'h7777, 16'hFFFF, 2'd1, 2'd0, 2'd0);
        scrub_req = 1'b1;
        @(negedge clk);
        scrub_req = 1'b0;
        vectors++; if (scrub_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b expected 1", scrub_busy); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++; if (scrub_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", scrub_busy); end
        vectors++; if (viol_count !== 2'd0) begin miscompares++; $display("FAIL midrst_viol: got %0d expected 0", viol_count); end
        vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_wr_ready: got %b expected 1", bus.wr_ready); end
        @(negedge clk);
        reset = 1'b1;
        rd_cycle(2'd3, 2'd0, 2'd0);
        vectors++; if (bus.rd_data !== 16'h0000 || bus.rd_lbl !== 2'd0 || bus.rd_denied !== 1'b0) begin miscompares++; $display("FAIL midrst_cleared: got %h/%0d/%b expected 0000/0/0", bus.rd_data, bus.rd_lbl, bus.rd_denied); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        scrub_req = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.wr_mask = '0;
        bus.wr_lbl_data = '0; bus.wr_lbl_idx = '0; bus.wr_lbl_ctx = '0;
        bus.rd_valid = 1'b0; bus.rd_idx = '0; bus.rd_lbl_idx = '0; bus.rd_clr = '0;

        test_reset();
        test_basic_rw();
        test_reject();
        test_mask();
        test_back_to_back();
        test_scrub();
        test_saturate();
        test_reset_mid_scrub();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
